rf_write_sched: RTL and testbench

- Write-port scheduler and scoreboard in front of the 32x32 register file (r0 hardwired zero, one write port, writes on posedge clk).
- Shares the single write port between the pipeline WB stage and a long-latency unit (LLU: mult/div, slow loads).
- Buffers LLU results in a small FIFO and tracks registers with outstanding LLU writes so decode can stall on RAW hazards.
- Bounds LLU starvation with a counter-driven pipeline hold.

---
 rtl/rf_write_sched.sv | 156 +++++++++++++++
 tb/tb_rf_write_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_sched.sv
// Write-port scheduler and LLU scoreboard for the 32x32 register file.
// This block shares one register-file write port between the WB stage and a
// long-latency unit (LLU). LLU results wait in a small FIFO. WB normally has
// priority on the port. A starvation counter limits how long a non-empty FIFO
// can lose the port: when the limit is reached, the FIFO head takes the port
// for one cycle and WB is told to hold its write.
// The pend bits mark registers that still have an LLU write outstanding, so
// decode can stall on read-after-write hazards.
module rf_write_sched #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipe_we,
  input  logic [4:0]              pipe_waddr,
  input  logic [31:0]             pipe_wdata,
  output logic                    pipe_hold,
  input  logic                    llu_issue,
  input  logic [4:0]              llu_issue_addr,
  input  logic                    llu_valid,
  output logic                    llu_ready,
  input  logic [4:0]              llu_addr,
  input  logic [31:0]             llu_data,
  input  logic [4:0]              rd_addr_A,
  input  logic [4:0]              rd_addr_B,
  output logic                    rd_pend_A,
  output logic                    rd_pend_B,
  output logic                    reg_we,
  output logic [4:0]              reg_W_addr,
  output logic [31:0]             wdata,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    sb_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]    r_fifo_addr [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_pend;
  logic          r_sb_err;

  logic          w_pipe_valid;
  logic          w_empty;
  logic          w_hold;
  logic          w_head_commit;
  logic          w_pipe_commit;
  logic          w_push;
  logic          w_issue;
  logic [4:0]    w_head_addr;
  logic [31:0]   w_head_data;
  logic [31:0]   w_set_mask;
  logic [31:0]   w_clr_mask;

  // A write to r0 does nothing, so it is not treated as a request for the port.
  assign w_pipe_valid  = pipe_we && (pipe_waddr != 5'd0);
  assign w_empty       = (r_count == '0);
  assign w_hold        = !w_empty && (r_starve == STARVE_MAX);
  // While reset is asserted, the port stays idle even if WB is presenting a write.
  assign w_head_commit = !rst && !w_empty && (w_hold || !w_pipe_valid);
  assign w_pipe_commit = !rst && !w_hold && w_pipe_valid;
  assign pipe_hold     = !rst && w_hold && w_pipe_valid;

  assign llu_ready     = (r_count != FULL_CNT);
  // An accepted result addressed to r0 is dropped: it is not pushed.
  assign w_push        = llu_valid && llu_ready && (llu_addr != 5'd0);
  assign w_issue       = llu_issue && (llu_issue_addr != 5'd0);

  assign w_head_addr   = r_fifo_addr[r_rd_ptr];
  assign w_head_data   = r_fifo_data[r_rd_ptr];
  assign fifo_count    = r_count;

  // Bit 0 of r_pend is never set, so a read of r0 never reports pending.
  assign rd_pend_A     = r_pend[rd_addr_A];
  assign rd_pend_B     = r_pend[rd_addr_B];
  assign sb_err        = r_sb_err;

  // Write-port mux: drive the FIFO head, or the WB write, or nothing.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the block can infer a latch.
    reg_we     = 1'b0;
    reg_W_addr = 5'd0;
    wdata      = 32'd0;
    if (w_head_commit) begin
      reg_we     = 1'b1;
      reg_W_addr = w_head_addr;
      wdata      = w_head_data;
    end else if (w_pipe_commit) begin
      reg_we     = 1'b1;
      reg_W_addr = pipe_waddr;
      wdata      = pipe_wdata;
    end
  end

  // FIFO storage: write the accepted LLU result into the slot at the write pointer.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the count and pointers decide which entries are valid.
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= llu_addr;
      r_fifo_data[r_wr_ptr] <= llu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_head_commit) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_head_commit})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter: count the cycles in which WB wins while the FIFO is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_empty || w_head_commit) begin
      r_starve <= '0;
    end else if (w_pipe_commit && (r_starve != STARVE_MAX)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  assign w_set_mask = w_issue       ? (32'd1 << llu_issue_addr) : 32'd0;
  assign w_clr_mask = w_head_commit ? (32'd1 << w_head_addr)    : 32'd0;

  // Scoreboard: an issue sets a pend bit and a head commit clears it.
  // An issue and a commit to the same register in one cycle leave the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend   <= 32'd0;
      r_sb_err <= 1'b0;
    end else begin
      r_pend   <= ((r_pend & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
      r_sb_err <= r_sb_err | (w_issue && r_pend[llu_issue_addr]);
    end
  end

endmodule

// File: tb/tb_rf_write_sched.sv
// Randomized and directed bench for rf_write_sched.
// A queue-based reference model, stepped once per cycle, predicts every
// register-file write and pushes it onto a scoreboard queue. A separate monitor
// pops from that queue and compares each write the DUT presents.
module tb_rf_write_sched;

  localparam int DEPTH  = 4;
  localparam int STARVE = 8;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_hold;
  logic        llu_issue;
  logic [4:0]  llu_issue_addr;
  logic        llu_valid;
  logic        llu_ready;
  logic [4:0]  llu_addr;
  logic [31:0] llu_data;
  logic [4:0]  rd_addr_A;
  logic [4:0]  rd_addr_B;
  logic        rd_pend_A;
  logic        rd_pend_B;
  logic        reg_we;
  logic [4:0]  reg_W_addr;
  logic [31:0] wdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic        sb_err;

  rf_write_sched #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .pipe_hold(pipe_hold),
    .llu_issue(llu_issue), .llu_issue_addr(llu_issue_addr),
    .llu_valid(llu_valid), .llu_ready(llu_ready),
    .llu_addr(llu_addr), .llu_data(llu_data),
    .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B),
    .rd_pend_A(rd_pend_A), .rd_pend_B(rd_pend_B),
    .reg_we(reg_we), .reg_W_addr(reg_W_addr), .wdata(wdata),
    .fifo_count(fifo_count), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  ent_t        m_fifo[$];
  ent_t        wq[$];
  bit   [31:0] m_pend = '0;
  int          m_starve = 0;
  bit          m_err = 1'b0;
  bit          m_hold = 1'b0;
  bit          m_ready = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict this cycle's outputs from the model state and the current inputs,
  // check the status outputs, then advance the model to the next clock edge.
  task automatic model_cycle();
    bit   pv, hold, head_c, pipe_c, acc;
    ent_t h;
    if (rst) begin
      check("rst_reg_we", reg_we, 0);
      check("rst_pipe_hold", pipe_hold, 0);
      check("rst_llu_ready", llu_ready, 1);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_rd_pend_A", rd_pend_A, 0);
      check("rst_rd_pend_B", rd_pend_B, 0);
      check("rst_sb_err", sb_err, 0);
      m_fifo.delete();
      m_pend   = '0;
      m_starve = 0;
      m_err    = 1'b0;
      m_hold   = 1'b0;
      m_ready  = 1'b1;
      return;
    end
    pv     = pipe_we && (pipe_waddr != 5'd0);
    hold   = (m_fifo.size() > 0) && (m_starve == STARVE);
    head_c = (m_fifo.size() > 0) && (hold || !pv);
    pipe_c = pv && !hold;
    if (head_c) begin
      h = m_fifo[0];
      wq.push_back(h);
    end else if (pipe_c) begin
      wq.push_back('{a: pipe_waddr, d: pipe_wdata});
    end
    m_hold  = hold && pv;
    m_ready = (m_fifo.size() < DEPTH);
    check("reg_we", reg_we, head_c || pipe_c);
    check("pipe_hold", pipe_hold, m_hold);
    check("llu_ready", llu_ready, m_ready);
    check("fifo_count", fifo_count, m_fifo.size());
    check("rd_pend_A", rd_pend_A, (rd_addr_A != 0) && m_pend[rd_addr_A]);
    check("rd_pend_B", rd_pend_B, (rd_addr_B != 0) && m_pend[rd_addr_B]);
    check("sb_err", sb_err, m_err);
    // next state
    acc = llu_valid && m_ready;
    if (m_fifo.size() == 0 || head_c) m_starve = 0;
    else if (pipe_c && m_starve < STARVE) m_starve++;
    if (llu_issue && llu_issue_addr != 0 && m_pend[llu_issue_addr]) m_err = 1'b1;
    if (head_c) begin
      m_pend[h.a] = 1'b0;
      void'(m_fifo.pop_front());
    end
    if (llu_issue && llu_issue_addr != 0) m_pend[llu_issue_addr] = 1'b1;
    if (acc && llu_addr != 0) m_fifo.push_back('{a: llu_addr, d: llu_data});
  endtask

  // Drive one cycle of inputs 2 time units after the edge, then run the model 1 unit later.
  task automatic step(input bit r, input bit pwe, input logic [4:0] pa, input logic [31:0] pd,
                      input bit iss, input logic [4:0] ia,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk);
    #2;
    rst = r; pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
    llu_issue = iss; llu_issue_addr = ia;
    llu_valid = lv; llu_addr = la; llu_data = ld;
    rd_addr_A = ra; rd_addr_B = rb;
    #1;
    model_cycle();
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
  endtask

  // Monitor: at every falling edge on which the DUT writes, pop one expected write and compare it.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (reg_we === 1'b1) begin
        if (wq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wr_unexpected: got addr %0d data %0h expected no write", reg_W_addr, wdata);
        end else begin
          e = wq.pop_front();
          check("wr_addr", reg_W_addr, e.a);
          check("wr_data", wdata, e.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          n_hold, hold_at, nres;
    bit          lv, pwe, keep_l;
    logic [4:0]  pa, la, ia;
    logic [31:0] pd, ld;

    rst = 1'b1; pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
    llu_issue = 0; llu_issue_addr = 0; llu_valid = 0; llu_addr = 0; llu_data = 0;
    rd_addr_A = 0; rd_addr_B = 0;

    // Reset, then a plain WB write with the FIFO empty
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    check("t1_reg_we", reg_we, 1);
    check("t1_addr", reg_W_addr, 5);
    check("t1_data", wdata, 32'hDEADBEEF);
    check("t1_hold", pipe_hold, 0);

    // Issue to r7, then the r7 result arrives, commits, and clears the pend bit
    step(0, 0, 0, 0, 1, 7, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 32'h1234, 7, 0);
    check("t2_pend_set", rd_pend_A, 1);
    idle(7, 0);
    check("t2_commit_we", reg_we, 1);
    check("t2_commit_addr", reg_W_addr, 7);
    check("t2_commit_data", wdata, 32'h1234);
    check("t2_pend_still", rd_pend_A, 1);
    idle(7, 0);
    check("t2_pend_clear", rd_pend_A, 0);

    // Fill the FIFO while WB writes every cycle; the starvation limit forces one hold
    d = 32'h100; n_hold = 0; hold_at = 0; nres = 0;
    for (int c = 1; c <= 14; c++) begin
      lv = (nres < 4);
      step(0, 1, 3, d, 0, 0, lv, 5'(10 + nres), 32'hA000 + nres, 0, 0);
      if (lv && m_ready) nres++;
      if (pipe_hold === 1'b1) begin n_hold++; hold_at = c; end
      if (c == 5) begin
        check("t3_full_count", fifo_count, 4);
        check("t3_full_not_ready", llu_ready, 0);
      end
      if (c == 10) check("t3_hold_head_addr", reg_W_addr, 10);
      if (c == 11) begin
        check("t3_represent_addr", reg_W_addr, 3);
        check("t3_represent_data", wdata, 32'h109);
      end
      if (!m_hold) d++;
    end
    check("t3_hold_count", n_hold, 1);
    check("t3_hold_cycle", hold_at, 10);
    for (int i = 0; i < 6; i++) idle(0, 0);
    check("t3_drained", fifo_count, 0);

    // Push and pop in the same cycle at count 2; six results go across the pointer wrap
    step(0, 1, 4, 32'h1, 0, 0, 1, 20, 32'hB020, 0, 0);
    step(0, 1, 4, 32'h2, 0, 0, 1, 21, 32'hB021, 0, 0);
    for (int k = 2; k < 6; k++) begin
      step(0, 0, 0, 0, 0, 0, 1, 5'(20 + k), 32'hB020 + k, 0, 0);
      check("t4_count_steady", fifo_count, 2);
    end
    idle(0, 0);
    check("t4_count_after", fifo_count, 2);
    idle(0, 0);
    idle(0, 0);
    idle(0, 0);
    check("t4_empty", fifo_count, 0);

    // Two issues to r9 set the sticky error; r0 issues and r0 results are ignored
    step(0, 0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
    check("t5_pend9", rd_pend_A, 1);
    idle(9, 0);
    check("t5_sb_err", sb_err, 1);
    idle(9, 0);
    idle(9, 0);
    check("t5_sb_err_sticky", sb_err, 1);
    step(0, 0, 0, 0, 1, 0, 1, 0, 32'hFFFF, 0, 0);
    check("t5_r0_no_we", reg_we, 0);
    idle(0, 0);
    check("t5_r0_no_push", fifo_count, 0);
    check("t5_r0_no_we2", reg_we, 0);

    // Reset with three FIFO entries and pend bits set
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 6, 32'h61, 1, 11, 1, 13, 32'hC013, 11, 12);
    step(0, 1, 6, 32'h62, 1, 12, 1, 14, 32'hC014, 11, 12);
    step(0, 1, 6, 32'h63, 0, 0, 1, 15, 32'hC015, 11, 12);
    check("t6_pendA_before", rd_pend_A, 1);
    check("t6_pendB_before", rd_pend_B, 1);
    step(1, 1, 6, 32'h64, 0, 0, 0, 0, 0, 11, 12);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_pendA", rd_pend_A, 0);
    check("t6_rst_pendB", rd_pend_B, 0);
    check("t6_rst_we", reg_we, 0);
    for (int i = 0; i < 4; i++) begin
      idle(11, 12);
      check("t6_no_stale_we", reg_we, 0);
    end

    // Randomized traffic that honours pipe_hold and llu_ready, with occasional resets
    pwe = 0; pa = 0; pd = 0; lv = 0; la = 0; ld = 0; keep_l = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 299) == 0);
      if (!m_hold) begin
        pwe = ($urandom_range(0, 2) != 0);
        pa  = 5'($urandom_range(0, 15));
        pd  = $urandom;
      end
      if (!keep_l) begin
        lv = ($urandom_range(0, 4) < 2);
        la = 5'($urandom_range(0, 15));
        ld = $urandom;
      end
      ia = 5'($urandom_range(0, 15));
      step(r, pwe, pa, pd, ($urandom_range(0, 3) == 0), ia, lv, la, ld,
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      keep_l = lv && !m_ready;
    end

    for (int i = 0; i < 12; i++) idle(0, 0);
    check("final_fifo_empty", fifo_count, 0);
    @(posedge clk);
    check("scoreboard_drained", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
